// File: rtl/pattern_seq_monitor_pkg.sv
// Purpose : shared defaults, step-index type and matcher event encoding for pattern_seq_monitor.
// Latency : n/a (types and constants only).
// Backpres: n/a.
// Contents: DEF_* parameter defaults, step_t (wide enough for SEQ_LEN up to 256),
//           match_ev_t (per-sample matcher outcome), idx_w() helper for select widths.
package pattern_mon_pkg;

   localparam int DEF_WIDTH    = 128;
   localparam int DEF_CHANNELS = 4;
   localparam int DEF_SEQ_LEN  = 4;
   localparam int DEF_CNT_W    = 16;

   // Step index is sized for the largest supported SEQ_LEN so one type serves every instance.
   localparam int STEP_W = 8;
   typedef logic [STEP_W-1:0] step_t;

   // What a valid sample does to a channel's matcher.
   typedef enum logic [2:0] {
      EV_NONE,           // no sample, loose mismatch, or sample discarded
      EV_ADVANCE,        // matched a non-final step
      EV_HIT,            // matched the final step
      EV_RESTART,        // strict mismatch, sample also fails step 0
      EV_RESTART_MATCH   // strict mismatch, sample re-tested and matches step 0
   } match_ev_t;

   // Select width for a count of n items; never zero so ports stay legal for n = 1.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/pattern_seq_monitor_if.sv
// Purpose : bundles the monitored data bus, pattern configuration and result outputs.
// Latency : n/a (wiring only).
// Backpres: none; the monitor samples every cycle data_valid is high.
// Modports: master drives data/config/clear and reads results; slave is the monitor side.
interface pattern_seq_monitor_if
   import pattern_mon_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int CHANNELS = DEF_CHANNELS,
   parameter int SEQ_LEN  = DEF_SEQ_LEN,
   parameter int CNT_W    = DEF_CNT_W
);
   localparam int CH_W  = idx_w(CHANNELS);
   localparam int IDX_W = idx_w(SEQ_LEN);

   logic                      data_valid;
   logic [WIDTH-1:0]          data;
   logic                      cfg_we;
   logic [CH_W-1:0]           cfg_ch;
   logic [IDX_W-1:0]          cfg_idx;
   logic [WIDTH-1:0]          cfg_pattern;
   logic [WIDTH-1:0]          cfg_mask;
   logic [CHANNELS-1:0]       cfg_strict;
   logic [CNT_W-1:0]          cfg_thresh;
   logic                      clear;
   logic [CHANNELS*CNT_W-1:0] hit_cnt;
   logic [CHANNELS-1:0]       alarm;
   logic                      any_alarm;

   modport master (
      output data_valid, data, cfg_we, cfg_ch, cfg_idx, cfg_pattern, cfg_mask,
             cfg_strict, cfg_thresh, clear,
      input  hit_cnt, alarm, any_alarm
   );

   modport slave (
      input  data_valid, data, cfg_we, cfg_ch, cfg_idx, cfg_pattern, cfg_mask,
             cfg_strict, cfg_thresh, clear,
      output hit_cnt, alarm, any_alarm
   );

endinterface

// File: rtl/pattern_seq_monitor_seq_channel.sv
// Purpose : one sequence matcher: SEQ_LEN pattern/mask steps, saturating hit counter, sticky alarm.
// Latency : hit_cnt/alarm update on the edge after the sample completing the sequence.
// Backpres: none; samples are consumed whenever data_valid is high.
// Ports   : clk, rst (async active-low); data_valid/data sample; clear; cfg_we/cfg_idx/
//           cfg_pattern/cfg_mask step write (already decoded for this channel); strict mode;
//           thresh alarm threshold; hit_cnt and alarm results.
module seq_channel
   import pattern_mon_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int SEQ_LEN = DEF_SEQ_LEN,
   parameter int CNT_W   = DEF_CNT_W,
   parameter int IDX_W   = idx_w(DEF_SEQ_LEN)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             data_valid,
   input  logic [WIDTH-1:0] data,
   input  logic             clear,
   input  logic             cfg_we,
   input  logic [IDX_W-1:0] cfg_idx,
   input  logic [WIDTH-1:0] cfg_pattern,
   input  logic [WIDTH-1:0] cfg_mask,
   input  logic             strict,
   input  logic [CNT_W-1:0] thresh,
   output logic [CNT_W-1:0] hit_cnt,
   output logic             alarm
);

   logic [WIDTH-1:0] pattern_q [SEQ_LEN];
   logic [WIDTH-1:0] mask_q    [SEQ_LEN];

   step_t            step_q, step_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             alarm_q, alarm_d;

   logic [WIDTH-1:0] cur_pat, cur_mask;
   logic             match_cur, match_first, at_last;
   match_ev_t        ev;

   // Pattern storage; cleared to all-zero so an unconfigured step matches anything.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < SEQ_LEN; i++) begin
            pattern_q[i] <= '0;
            mask_q[i]    <= '0;
         end
      end else begin
         for (int i = 0; i < SEQ_LEN; i++) begin
            if (cfg_we && (int'(cfg_idx) == i)) begin
               pattern_q[i] <= cfg_pattern;
               mask_q[i]    <= cfg_mask;
            end
         end
      end
   end

   // Pattern/mask of the current step, selected with an explicit compare so the
   // oversized step index never addresses past the array.
   always_comb begin
      cur_pat  = pattern_q[0];
      cur_mask = mask_q[0];
      for (int i = 1; i < SEQ_LEN; i++) begin
         if (int'(step_q) == i) begin
            cur_pat  = pattern_q[i];
            cur_mask = mask_q[i];
         end
      end
   end

   assign match_cur   = ((data ^ cur_pat) & cur_mask) == '0;
   assign match_first = ((data ^ pattern_q[0]) & mask_q[0]) == '0;
   assign at_last     = (int'(step_q) == SEQ_LEN - 1);

   // Classify the sample. A config write to this channel or a clear discards it.
   always_comb begin
      ev = EV_NONE;
      if (data_valid && !cfg_we && !clear) begin
         if (match_cur) begin
            ev = at_last ? EV_HIT : EV_ADVANCE;
         end else if (strict) begin
            ev = match_first ? EV_RESTART_MATCH : EV_RESTART;
         end
      end
   end

   always_comb begin
      step_d  = step_q;
      cnt_d   = cnt_q;
      alarm_d = alarm_q;
      case (ev)
         EV_ADVANCE:       step_d = step_q + 1'b1;
         EV_HIT: begin
            step_d = '0;
            cnt_d  = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
            // Threshold 0 disables new alarms; an already-set alarm is untouched.
            if ((thresh != '0) && (cnt_d >= thresh)) begin
               alarm_d = 1'b1;
            end
         end
         EV_RESTART:       step_d = '0;
         // Only reachable with SEQ_LEN > 1: at SEQ_LEN = 1 a step-0 retest equals the failed test.
         EV_RESTART_MATCH: step_d = step_t'(1);
         default:          step_d = step_q;
      endcase
      if (clear) begin
         step_d  = '0;
         cnt_d   = '0;
         alarm_d = 1'b0;
      end else if (cfg_we) begin
         step_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         step_q  <= '0;
         cnt_q   <= '0;
         alarm_q <= 1'b0;
      end else begin
         step_q  <= step_d;
         cnt_q   <= cnt_d;
         alarm_q <= alarm_d;
      end
   end

   assign hit_cnt = cnt_q;
   assign alarm   = alarm_q;

endmodule

// File: rtl/pattern_seq_monitor.sv
// Purpose : observation-only multi-channel pattern sequence monitor with hit counters and alarms.
// Latency : one cycle from completing sample to hit_cnt/alarm; config writes apply next cycle.
// Backpres: none; every cycle with data_valid high is sampled by all channels.
// Ports   : clk, rst (async active-low, deassertion synchronised externally);
//           bus (slave modport): data_valid/data, cfg_* step writes, clear, hit_cnt/alarm/any_alarm.
module pattern_seq_monitor
   import pattern_mon_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int CHANNELS = DEF_CHANNELS,
   parameter int SEQ_LEN  = DEF_SEQ_LEN,
   parameter int CNT_W    = DEF_CNT_W
) (
   input  logic                 clk,
   input  logic                 rst,
   pattern_seq_monitor_if.slave bus
);

   localparam int IDX_W = idx_w(SEQ_LEN);

   logic [CHANNELS*CNT_W-1:0] hit_cnt_flat;
   logic [CHANNELS-1:0]       alarm_vec;
   logic                      cfg_ok;

   // Writes addressing a channel or step that does not exist are dropped entirely,
   // including the step reset a valid write would cause.
   assign cfg_ok = bus.cfg_we
                && (int'(bus.cfg_ch)  < CHANNELS)
                && (int'(bus.cfg_idx) < SEQ_LEN);

   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      logic ch_we;
      assign ch_we = cfg_ok && (int'(bus.cfg_ch) == c);

      seq_channel #(
         .WIDTH   (WIDTH),
         .SEQ_LEN (SEQ_LEN),
         .CNT_W   (CNT_W),
         .IDX_W   (IDX_W)
      ) u_seq_channel (
         .clk         (clk),
         .rst         (rst),
         .data_valid  (bus.data_valid),
         .data        (bus.data),
         .clear       (bus.clear),
         .cfg_we      (ch_we),
         .cfg_idx     (bus.cfg_idx),
         .cfg_pattern (bus.cfg_pattern),
         .cfg_mask    (bus.cfg_mask),
         .strict      (bus.cfg_strict[c]),
         .thresh      (bus.cfg_thresh),
         .hit_cnt     (hit_cnt_flat[c*CNT_W +: CNT_W]),
         .alarm       (alarm_vec[c])
      );
   end

   assign bus.hit_cnt   = hit_cnt_flat;
   assign bus.alarm     = alarm_vec;
   assign bus.any_alarm = |alarm_vec;

endmodule
